// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    localparam int STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// rtl/mem_arbiter_arb_pick.sv - grant decision between fetch and data requesters
// Data side wins ties unless the starvation guard is asserted.
module arb_pick (
    input  logic i_req,
    input  logic d_req,
    input  logic starve_hit,
    output logic pick_i,
    output logic pick_d
);

    assign pick_i = i_req & (~d_req | starve_hit);
    assign pick_d = d_req & ~pick_i;

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester single-outstanding memory port arbiter
// Optional fetch starvation guard enabled by MEM_ARB_STARVE_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        iReq,
    input  logic [31:0] iAddr,
    output logic        iGnt,
    output logic        iRvalid,
    output logic [31:0] iRdata,
    input  logic        dReq,
    input  logic        dWen,
    input  logic [31:0] dAddr,
    input  logic [31:0] dWdata,
    output logic        dGnt,
    output logic        dRvalid,
    output logic [31:0] dRdata,
    output logic        memReq,
    output logic        memWen,
    output logic [31:0] memAddr,
    output logic [31:0] memWdata,
    input  logic        memReady,
    input  logic        memRvalid,
    input  logic [31:0] memRdata
);

    state_e      state_q, state_d;
    owner_e      owner_q, owner_d;
    logic        wen_q, wen_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        mem_req_q, mem_req_d;
    logic        i_rvalid_q, i_rvalid_d;
    logic        d_rvalid_q, d_rvalid_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        pick_i, pick_d, starve_hit;

    arb_pick u_pick (
        .i_req      (iReq),
        .d_req      (dReq),
        .starve_hit (starve_hit),
        .pick_i     (pick_i),
        .pick_d     (pick_d)
    );

`ifdef MEM_ARB_STARVE_EN
    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!iReq || iGnt) begin
            starve_cnt_d = '0;
        end else if (dGnt) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign starve_hit = (starve_cnt_q == CNT_W'(STARVE_MAX));
`else
    assign starve_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (iReq || dReq) state_d = ISSUE;
            ISSUE:   if (memReady) state_d = wen_q ? IDLE : WAIT;
            WAIT:    if (memRvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grants are the only combinational outputs; everything else is staged into _d.
    always_comb begin
        iGnt       = 1'b0;
        dGnt       = 1'b0;
        owner_d    = owner_q;
        wen_d      = wen_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        i_rvalid_d = 1'b0;
        d_rvalid_d = 1'b0;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
        mem_req_d  = (state_d == ISSUE);

        if (state_q == IDLE && rst_n) begin
            iGnt = pick_i;
            dGnt = pick_d;
            if (pick_i) begin
                owner_d = OWN_I;
                wen_d   = 1'b0;
                addr_d  = iAddr;
                wdata_d = '0;
            end else if (pick_d) begin
                owner_d = OWN_D;
                wen_d   = dWen;
                addr_d  = dAddr;
                wdata_d = dWdata;
            end
        end

        if (state_q == ISSUE && memReady && wen_q) begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = '0;
        end

        if (state_q == WAIT && memRvalid) begin
            if (owner_q == OWN_I) begin
                i_rvalid_d = 1'b1;
                i_rdata_d  = memRdata;
            end else begin
                d_rvalid_d = 1'b1;
                d_rdata_d  = memRdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q    <= OWN_I;
            wen_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            mem_req_q  <= 1'b0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            owner_q    <= owner_d;
            wen_q      <= wen_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            mem_req_q  <= mem_req_d;
            i_rvalid_q <= i_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign memReq   = mem_req_q;
    assign memWen   = wen_q;
    assign memAddr  = addr_q;
    assign memWdata = wdata_q;
    assign iRvalid  = i_rvalid_q;
    assign iRdata   = i_rdata_q;
    assign dRvalid  = d_rvalid_q;
    assign dRdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iReq = 1'b0;
    logic [31:0] iAddr = '0;
    logic        iGnt, iRvalid;
    logic [31:0] iRdata;
    logic        dReq = 1'b0;
    logic        dWen = 1'b0;
    logic [31:0] dAddr = '0;
    logic [31:0] dWdata = '0;
    logic        dGnt, dRvalid;
    logic [31:0] dRdata;
    logic        memReq, memWen;
    logic [31:0] memAddr, memWdata;
    logic        memReady = 1'b0;
    logic        memRvalid = 1'b0;
    logic [31:0] memRdata = '0;

    int tests_run = 0;
    int tests_failed = 0;

    mem_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .iReq(iReq), .iAddr(iAddr), .iGnt(iGnt), .iRvalid(iRvalid), .iRdata(iRdata),
        .dReq(dReq), .dWen(dWen), .dAddr(dAddr), .dWdata(dWdata),
        .dGnt(dGnt), .dRvalid(dRvalid), .dRdata(dRdata),
        .memReq(memReq), .memWen(memWen), .memAddr(memAddr), .memWdata(memWdata),
        .memReady(memReady), .memRvalid(memRvalid), .memRdata(memRdata)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    initial begin
        int dgnt_cnt;
        int i_seen;

        repeat (2) next_cycle();
        settle();
        check_eq("rst_memReq", memReq, 0);
        check_eq("rst_iRvalid", iRvalid, 0);
        check_eq("rst_dRvalid", dRvalid, 0);
        check_eq("rst_memAddr", memAddr, 0);
        check_eq("rst_iRdata", iRdata, 0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // single fetch read, best-case latency
        iReq = 1'b1; iAddr = 32'h100; memReady = 1'b1;
        settle();
        check_eq("a_iGnt_c0", iGnt, 1);
        check_eq("a_dGnt_c0", dGnt, 0);
        check_eq("a_memReq_c0", memReq, 0);
        next_cycle();
        iReq = 1'b0;
        settle();
        check_eq("a_memReq_c1", memReq, 1);
        check_eq("a_memAddr_c1", memAddr, 32'h100);
        check_eq("a_memWen_c1", memWen, 0);
        next_cycle();
        memReady = 1'b0; memRvalid = 1'b1; memRdata = 32'hDEADBEEF;
        settle();
        check_eq("a_memReq_c2", memReq, 0);
        check_eq("a_iRvalid_c2", iRvalid, 0);
        next_cycle();
        memRvalid = 1'b0;
        settle();
        check_eq("a_iRvalid_c3", iRvalid, 1);
        check_eq("a_iRdata_c3", iRdata, 32'hDEADBEEF);
        next_cycle();
        settle();
        check_eq("a_iRvalid_c4", iRvalid, 0);
        check_eq("a_iRdata_hold", iRdata, 32'hDEADBEEF);

        // simultaneous requests: data write first, then fetch
        next_cycle();
        iReq = 1'b1; iAddr = 32'h300;
        dReq = 1'b1; dWen = 1'b1; dAddr = 32'h200; dWdata = 32'h55;
        settle();
        check_eq("b_dGnt", dGnt, 1);
        check_eq("b_iGnt_c0", iGnt, 0);
        next_cycle();
        dReq = 1'b0; dWen = 1'b0; memReady = 1'b1;
        settle();
        check_eq("b_memReq", memReq, 1);
        check_eq("b_memWen", memWen, 1);
        check_eq("b_memAddr", memAddr, 32'h200);
        check_eq("b_memWdata", memWdata, 32'h55);
        check_eq("b_iGnt_issue", iGnt, 0);
        next_cycle();
        memReady = 1'b0;
        settle();
        check_eq("b_dRvalid", dRvalid, 1);
        check_eq("b_dRdata_wack", dRdata, 0);
        check_eq("b_iGnt_c2", iGnt, 1);
        next_cycle();
        iReq = 1'b0; memReady = 1'b1;
        settle();
        check_eq("b_dRvalid_off", dRvalid, 0);
        check_eq("b_memAddr_i", memAddr, 32'h300);
        check_eq("b_memWen_i", memWen, 0);
        next_cycle();
        memReady = 1'b0; memRvalid = 1'b1; memRdata = 32'h12345678;
        next_cycle();
        memRvalid = 1'b0;
        settle();
        check_eq("b_iRvalid", iRvalid, 1);
        check_eq("b_iRdata", iRdata, 32'h12345678);
        next_cycle();

        // stray response while idle is ignored
        memRvalid = 1'b1; memRdata = 32'h00000BAD;
        next_cycle();
        memRvalid = 1'b0;
        settle();
        check_eq("c_stray_iRvalid", iRvalid, 0);
        check_eq("c_stray_dRvalid", dRvalid, 0);
        check_eq("c_stray_iRdata", iRdata, 32'h12345678);
        check_eq("c_stray_dRdata", dRdata, 0);

        // data read with memory stalling in ISSUE; stray memRvalid there is ignored
        next_cycle();
        dReq = 1'b1; dWen = 1'b0; dAddr = 32'h400;
        settle();
        check_eq("c_dGnt", dGnt, 1);
        next_cycle();
        dReq = 1'b0; dAddr = 32'h0; memRvalid = 1'b1; memRdata = 32'hBAD0BAD0;
        for (int k = 0; k < 6; k++) begin
            memReady = (k == 5);
            settle();
            check_eq("c_stall_memReq", memReq, 1);
            check_eq("c_stall_memAddr", memAddr, 32'h400);
            check_eq("c_stall_memWen", memWen, 0);
            check_eq("c_stall_dRvalid", dRvalid, 0);
            next_cycle();
        end
        memReady = 1'b0; memRdata = 32'hCAFEF00D;
        settle();
        check_eq("c_wait_memReq", memReq, 0);
        next_cycle();
        memRvalid = 1'b0;
        settle();
        check_eq("c_dRvalid", dRvalid, 1);
        check_eq("c_dRdata", dRdata, 32'hCAFEF00D);
        check_eq("c_iRvalid", iRvalid, 0);

        // reset while waiting for a response aborts the transaction
        next_cycle();
        iReq = 1'b1; iAddr = 32'h500; memReady = 1'b1;
        next_cycle();
        iReq = 1'b0;
        next_cycle();
        memReady = 1'b0;
        rst_n = 1'b0;
        memRvalid = 1'b1; memRdata = 32'h77777777;
        settle();
        check_eq("d_rst_memReq", memReq, 0);
        check_eq("d_rst_iRdata", iRdata, 0);
        check_eq("d_rst_dRdata", dRdata, 0);
        check_eq("d_rst_memAddr", memAddr, 0);
        next_cycle();
        rst_n = 1'b1;
        settle();
        check_eq("d_post_iRvalid", iRvalid, 0);
        check_eq("d_post_dRvalid", dRvalid, 0);
        next_cycle();
        memRvalid = 1'b0;
        settle();
        check_eq("d_post2_iRvalid", iRvalid, 0);
        check_eq("d_post2_iRdata", iRdata, 0);
        iReq = 1'b1; iAddr = 32'h600;
        settle();
        check_eq("d_idle_iGnt", iGnt, 1);
        next_cycle();
        iReq = 1'b0;
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // continuous contention: starvation guard behaviour
        iReq = 1'b1; iAddr = 32'h700;
        dReq = 1'b1; dWen = 1'b1; dAddr = 32'h800; dWdata = 32'h1;
        memReady = 1'b1;
        dgnt_cnt = 0;
        i_seen = 0;
        for (int k = 0; k < 12; k++) begin
            settle();
            if (iGnt) begin
                i_seen = 1;
                break;
            end
            if (dGnt) dgnt_cnt++;
            next_cycle();
        end
        iReq = 1'b0; dReq = 1'b0; memReady = 1'b0;
`ifdef MEM_ARB_STARVE_EN
        check_eq("e_dgnt_before_i", dgnt_cnt, 4);
        check_eq("e_i_seen", i_seen, 1);
`else
        check_eq("e_dgnt_count", dgnt_cnt, 6);
        check_eq("e_i_never", i_seen, 0);
`endif
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
